// File: rtl/ccff_loader_if.sv
// Bundles the bitstream stream port and the serial config-chain port.
// Pure wiring; carries no state and adds no latency.
// s_valid/s_ready is a plain valid-ready handshake; the chain side has no backpressure.
interface ccff_loader_if #(
    parameter int WORD_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              ccff_head;
    logic              ccff_tail;
    logic              ccff_shift_en;

    // Source of the bitstream, owner of the chain tail.
    modport master (
        output s_valid,
        output s_data,
        output ccff_tail,
        input  s_ready,
        input  ccff_head,
        input  ccff_shift_en
    );

    // The loader itself.
    modport slave (
        input  s_valid,
        input  s_data,
        input  ccff_tail,
        output s_ready,
        output ccff_head,
        output ccff_shift_en
    );
endinterface

// File: rtl/ccff_loader.sv
// Serialises a word stream into a ccff chain, LSB first; optional CRC read-back (macro CCFF_VERIFY_EN).
// Latency: 1 accept cycle + k shift cycles per word; with verify, CHAIN_LEN extra recirculation cycles.
// Backpressure: s_ready only while the word buffer is empty in LOAD; chain stalls (shift_en=0) meanwhile.
module ccff_loader #(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8
) (
    input  logic         prog_clk,
    input  logic         pReset,
    input  logic         start,
    ccff_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int BCNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CHAIN_C  = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
`ifdef CCFF_VERIFY_EN
        VERIFY = 2'd2,
`endif
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic [BCNT_W-1:0]   buf_cnt_q, buf_cnt_d;
    logic                head_q, head_d;
    logic [CNT_W-1:0]    remain;
    logic [BCNT_W-1:0]   take;

`ifdef CCFF_VERIFY_EN
    logic [7:0] crc_q, crc_d;
    logic [7:0] vcrc_q, vcrc_d;
    logic [7:0] vcrc_nxt;
    logic       err_q, err_d;

    // Serial CRC-8, polynomial x^8+x^2+x+1.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign err = err_q;
`else
    logic unused_tail;
    assign unused_tail = bus.ccff_tail;
    assign err = 1'b0;
`endif

    assign busy = (state_q != IDLE);

    // Bits still owed to the chain decide how much of the next word is used.
    always_comb begin
        remain = CHAIN_C - bit_cnt_q;
        take   = BCNT_W'(WORD_W);
        if (int'(remain) < WORD_W) begin
            take = BCNT_W'(remain);
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d           = state_q;
        bit_cnt_d         = bit_cnt_q;
        buf_d             = buf_q;
        buf_cnt_d         = buf_cnt_q;
        head_d            = head_q;
        bus.s_ready       = 1'b0;
        bus.ccff_shift_en = 1'b0;
        bus.ccff_head     = head_q;
        done              = 1'b0;
`ifdef CCFF_VERIFY_EN
        crc_d    = crc_q;
        vcrc_d   = vcrc_q;
        vcrc_nxt = crc8_step(vcrc_q, bus.ccff_tail);
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    bit_cnt_d = '0;
                    buf_d     = '0;
                    buf_cnt_d = '0;
`ifdef CCFF_VERIFY_EN
                    crc_d  = 8'h00;
                    vcrc_d = 8'h00;
                    err_d  = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (buf_cnt_q == '0) begin
                    bus.s_ready = 1'b1;
                    if (bus.s_valid) begin
                        buf_d     = bus.s_data;
                        buf_cnt_d = take;
                    end
                end else begin
                    bus.ccff_shift_en = 1'b1;
                    bus.ccff_head     = buf_q[0];
                    head_d            = buf_q[0];
                    buf_d             = buf_q >> 1;
                    buf_cnt_d         = buf_cnt_q - BCNT_W'(1);
                    bit_cnt_d         = bit_cnt_q + CNT_W'(1);
`ifdef CCFF_VERIFY_EN
                    crc_d = crc8_step(crc_q, buf_q[0]);
`endif
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        buf_cnt_d = '0;
`ifdef CCFF_VERIFY_EN
                        state_d = VERIFY;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef CCFF_VERIFY_EN
            VERIFY: begin
                // Recirculate tail into head so the chain ends where it started.
                bus.ccff_shift_en = 1'b1;
                bus.ccff_head     = bus.ccff_tail;
                head_d            = bus.ccff_tail;
                vcrc_d            = vcrc_nxt;
                bit_cnt_d         = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = DONE;
                    if (vcrc_nxt != crc_q) begin
                        err_d = 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            buf_q     <= '0;
            buf_cnt_q <= '0;
            head_q    <= 1'b0;
`ifdef CCFF_VERIFY_EN
            crc_q  <= 8'h00;
            vcrc_q <= 8'h00;
            err_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            buf_q     <= buf_d;
            buf_cnt_q <= buf_cnt_d;
            head_q    <= head_d;
`ifdef CCFF_VERIFY_EN
            crc_q  <= crc_d;
            vcrc_q <= vcrc_d;
            err_q  <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: table of load scenarios against a 36-bit chain model,
// with expectations queued at start and checked when done pulses,
// plus hand sequences for reset mid-load and ignored start pulses.
module tb_ccff_loader;
    localparam int CL = 36;
`ifdef CCFF_VERIFY_EN
    localparam int VEXTRA = 36;
    localparam bit HAS_V  = 1'b1;
`else
    localparam int VEXTRA = 0;
    localparam bit HAS_V  = 1'b0;
`endif
    localparam logic [35:0] IMG0 = 36'h9_00FF3CA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, err;
    logic [35:0] chain;
    logic        flip_now;
    int          tests = 0;
    int          fails = 0;

    ccff_loader_if #(.WORD_W(8)) bus ();

    ccff_loader #(.CHAIN_LEN(CL), .WORD_W(8)) dut (
        .prog_clk (clk),
        .pReset   (rst),
        .start    (start),
        .bus      (bus.slave),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Chain model: head enters at the top, tail is bit 0, so chain[i] is bitstream bit i.
    always @(posedge clk) begin
        if (bus.ccff_shift_en) chain <= {bus.ccff_head, chain[35:1]};
    end
    assign bus.ccff_tail = chain[0] ^ flip_now;

    typedef struct {
        logic [4:0][7:0] w;
        int              gap_word;
        int              gap_len;
        bit              flip;
        int              exp_done;
        logic [35:0]     exp_load;
        logic [35:0]     exp_img;
        bit              exp_err;
    } vec_t;

    typedef struct {
        int          done_cyc;
        int          shifts;
        bit          err;
    } exp_t;

    exp_t sb[$];
    vec_t vt[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic run_load(input vec_t v, input bit extra_starts);
        exp_t        e;
        int          wi;
        int          gap_left;
        int          shifts;
        int          dones;
        int          done_c;
        bit          gap_started;
        bit          load_end;
        logic [35:0] img_load;
        e.done_cyc  = v.exp_done;
        e.shifts    = CL + VEXTRA;
        e.err       = v.exp_err;
        sb.push_back(e);
        wi = 0; gap_left = v.gap_len; shifts = 0; dones = 0; done_c = -1;
        gap_started = 1'b0; img_load = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            bus.s_valid = (wi < 5) && !(wi == v.gap_word && gap_left > 0);
            bus.s_data  = (wi < 5) ? v.w[wi] : 8'h00;
            flip_now    = v.flip && (shifts == CL + 10);
            start       = extra_starts && (c == 10 || c == v.exp_done);
            @(negedge clk);
            if (c == 1) check("err_clear_on_start", 64'(err), 64'(0));
            if (wi == v.gap_word && gap_left > 0 && (bus.s_ready || gap_started)) begin
                gap_started = 1'b1;
                check("gap_s_ready", 64'(bus.s_ready), 64'(1));
                check("gap_shift_en", 64'(bus.ccff_shift_en), 64'(0));
                gap_left--;
            end
            if (bus.s_valid && bus.s_ready) wi++;
            load_end = 1'b0;
            if (bus.ccff_shift_en) begin
                shifts++;
                load_end = (shifts == CL);
            end
            if (done) begin
                dones++;
                if (dones == 1) begin
                    done_c = c;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("done_cycle", 64'(c), 64'(e.done_cyc));
                        check("shift_count", 64'(shifts), 64'(e.shifts));
                        check("err_at_done", 64'(err), 64'(e.err));
                        check("busy_at_done", 64'(busy), 64'(1));
                    end
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (load_end) img_load = chain;
            if (done_c > 0 && c >= done_c + 4) break;
        end
        bus.s_valid = 1'b0;
        flip_now    = 1'b0;
        if (done_c < 0) begin
            tests++; fails++;
            $display("FAIL done_timeout: no done within 200 cycles, expected at %0d", v.exp_done);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        check("done_pulses", 64'(dones), 64'(1));
        check("image_after_load", 64'(img_load), 64'(v.exp_load));
        check("image_final", 64'(chain), 64'(v.exp_img));
        check("busy_after", 64'(busy), 64'(0));
        check("err_held", 64'(err), 64'(v.exp_err));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flip_now = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = 8'h00;
        chain = '0;

        vt[0] = '{w: {8'hF9, 8'h00, 8'hFF, 8'h3C, 8'hA5}, gap_word: -1, gap_len: 0, flip: 1'b0,
                  exp_done: 42 + VEXTRA, exp_load: IMG0, exp_img: IMG0, exp_err: 1'b0};
        vt[1] = '{w: {8'hF9, 8'h00, 8'hFF, 8'h3C, 8'hA5}, gap_word: 2, gap_len: 3, flip: 1'b0,
                  exp_done: 45 + VEXTRA, exp_load: IMG0, exp_img: IMG0, exp_err: 1'b0};
        vt[2] = '{w: {8'hF9, 8'h00, 8'hFF, 8'h3C, 8'hA5}, gap_word: -1, gap_len: 0, flip: 1'b1,
                  exp_done: 42 + VEXTRA, exp_load: IMG0,
                  exp_img: HAS_V ? (IMG0 ^ 36'h400) : IMG0, exp_err: HAS_V};
        vt[3] = '{w: {8'h9A, 8'h78, 8'h56, 8'h34, 8'h12}, gap_word: -1, gap_len: 0, flip: 1'b0,
                  exp_done: 42 + VEXTRA, exp_load: 36'hA_78563412, exp_img: 36'hA_78563412, exp_err: 1'b0};
        vt[4] = '{w: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, gap_word: -1, gap_len: 0, flip: 1'b0,
                  exp_done: 42 + VEXTRA, exp_load: 36'hF_FFFFFFFF, exp_img: 36'hF_FFFFFFFF, exp_err: 1'b0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              64'({bus.s_ready, bus.ccff_shift_en, bus.ccff_head, busy, done, err}), 64'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_load(vt[i], 1'b0);

        // Start pulses in LOAD and in the DONE cycle must not spawn a second load.
        run_load(vt[0], 1'b1);

        // Reset on cycle 20 of a load, with start and s_valid also high.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 8'hA5;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; bus.s_valid = 1'b0;
        @(negedge clk);
        check("reset_midload_outputs",
              64'({bus.s_ready, bus.ccff_shift_en, bus.ccff_head, busy, done, err}), 64'(0));
        @(posedge clk); #1;

        // Reset wins over start in IDLE.
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset_beats_start_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;

        // A full load still runs after the aborted one.
        run_load(vt[3], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 36, meaning the number of configuration flip-flops in the target ccff chain (18 two-bit mux memories).
REQ-002 SHALL have parameter WORD_W, default 8, meaning the bitstream word width on the input port.
REQ-003 SHALL have port prog_clk, input, 1 bit: the single clock; every register in the block samples on its rising edge.
REQ-004 SHALL have port pReset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to begin a chain load.
REQ-006 SHALL have port s_valid, input, 1 bit: the bitstream word is valid.
REQ-007 SHALL have port s_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 SHALL have port s_data, input, WORD_W bits: the bitstream word, shifted out LSB first.
REQ-009 SHALL have port ccff_head, output, 1 bit: serial data driven into the chain head.
REQ-010 SHALL have port ccff_tail, input, 1 bit: serial data returned from the chain tail.
REQ-011 SHALL have port ccff_shift_en, output, 1 bit: chain clock enable; the chain advances one bit on each prog_clk edge where this is 1.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1 bit: a one-cycle pulse when a load completes.
REQ-014 SHALL have port err, output, 1 bit: sticky verify-mismatch flag.

Function
REQ-015 SHALL implement the states IDLE, LOAD, VERIFY (only with the macro compiled in) and DONE.
REQ-016 SHALL move from IDLE to LOAD on the edge after start=1 is sampled in IDLE; at that transition it SHALL clear the bit counter, the word buffer and the CRC, and SHALL clear err.
REQ-017 SHALL ignore start in every state other than IDLE.
REQ-018 SHALL assert s_ready=1 only in LOAD while the word buffer is empty; a word is accepted on s_valid&&s_ready.
REQ-019 SHALL shift after acceptance: on each following cycle it drives ccff_shift_en=1 and ccff_head=buffer[0], then shifts the buffer right by one and increments the bit counter.
REQ-020 SHALL shift min(WORD_W, CHAIN_LEN-bits_sent) bits per word; unused upper bits of the final word are discarded.
REQ-021 SHALL therefore spend one accept cycle plus k shift cycles per word; with defaults and s_valid held high, LOAD lasts 5+36=41 cycles.
REQ-022 SHALL hold ccff_shift_en=0 while the buffer is empty, including while waiting on s_valid=0; ccff_head SHALL hold its last value when not shifting.
REQ-023 SHALL leave LOAD on the edge after the cycle in which bit CHAIN_LEN-1 is shifted, going to VERIFY if compiled in and otherwise to DONE.
REQ-024 SHALL hold DONE for exactly one cycle with done=1 and busy=1, then go to IDLE.
REQ-025 SHALL keep the bit counter at clog2(CHAIN_LEN+1) bits, so it SHALL never wrap within a load.

Reset
REQ-026 SHALL, when pReset=1 at an edge, force state IDLE, the counter, the buffer and the CRC to 0, and the outputs s_ready=0, ccff_shift_en=0, ccff_head=0, busy=0, done=0 and err=0.
REQ-027 SHALL abort a load in progress on reset; the chain contents are then undefined and a new start is required.
REQ-028 SHALL give pReset priority over start and over s_valid in the same cycle.

Configuration
REQ-029 SHALL use the macro CCFF_VERIFY_EN to compile the VERIFY state in or out.
REQ-030 SHALL, with CCFF_VERIFY_EN defined, update a CRC-8 (polynomial x^8+x^2+x+1, init 0x00) with every bit driven on ccff_head during LOAD.
REQ-031 SHALL, with CCFF_VERIFY_EN defined, run VERIFY for CHAIN_LEN cycles with ccff_shift_en=1 and ccff_head=ccff_tail, recirculating the chain so its contents end unchanged.
REQ-032 SHALL, during VERIFY, compute a second CRC-8 over ccff_tail.
REQ-033 SHALL, on the final VERIFY cycle, set err=1 if the two CRCs differ, then go to DONE.
REQ-034 SHALL, without CCFF_VERIFY_EN, contain no VERIFY state and no CRC logic, tie err to 0, and go straight from LOAD to DONE.

Verification
REQ-035 SHALL cover default parameters, no macro, s_valid always high, words 0xA5,0x3C,0xFF,0x00,0xF9 -> done at cycle 42 after start, 36 shift_en cycles, and a chain model holding the bits LSB-first with only 1001 taken from 0xF9.
REQ-036 SHALL cover s_valid dropped for 3 cycles before word 3 -> s_ready stays 1, shift_en 0 for those 3 cycles, done delayed by exactly 3 cycles, and the chain image unchanged.
REQ-037 SHALL cover CCFF_VERIFY_EN with an ideal chain model -> done at cycle 78, err=0, and chain contents after DONE equal to those after LOAD.
REQ-038 SHALL cover CCFF_VERIFY_EN with the model flipping tail bit 10 during VERIFY -> err=1 with done, err held until the next start, and cleared on the IDLE->LOAD transition.
REQ-039 SHALL cover pReset=1 on cycle 20 of LOAD -> on the next cycle all outputs are 0 and the state is IDLE; a following start runs a full 41-cycle load.
REQ-040 SHALL cover start pulsed during LOAD and in the DONE cycle -> no effect, with exactly one done pulse per accepted start.
